tail_light_seq: RTL

- Lamp-side driver for the turn-signal path: consumes left/right/hazard switch requests and drives the six tail lamps in the outward-sweep pattern.
- Contains an internal prescaler that produces a one-cycle tick.
- The lamp state machine advances only on that tick, so the pattern is visible on the board while staying fast in simulation.
- Sits between the switch inputs and the board LED pins.

---
 rtl/tail_light_seq.sv | 105 ++++++++++
 1 files changed

// File: rtl/tail_light_seq.sv
// Turn-signal lamp sequencer: a prescaler tick steps an outward-sweep FSM over six tail lamps.
// Optional hazard mode is enabled by defining TAIL_LIGHT_HAZARD_EN.
module tail_light_seq #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = $clog2(TICK_DIV + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic left,
  input  logic right,
  input  logic hazard,
  output logic la,
  output logic lb,
  output logic lc,
  output logic ra,
  output logic rb,
  output logic rc,
  output logic tick
);

  typedef enum logic [2:0] {IDLE, L1, L2, L3, R1, R2, R3, HAZ} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             haz_req;
  logic [5:0]       lamps;

`ifdef TAIL_LIGHT_HAZARD_EN
  assign haz_req = hazard | (left & right);
`else
  logic hazard_unused;
  assign hazard_unused = hazard;
  assign haz_req       = 1'b0;
`endif

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Moore decode; a hazard request at a tick pre-empts any sweep in progress.
  always_comb begin
    state_d = state_q;
    lamps   = 6'b000_000;
    case (state_q)
      IDLE: begin
        if (tick) begin
          if (haz_req)             state_d = HAZ;
          else if (left && !right) state_d = L1;
          else if (right && !left) state_d = R1;
        end
      end
      L1: begin
        lamps = 6'b100_000;
        if (tick) state_d = haz_req ? HAZ : L2;
      end
      L2: begin
        lamps = 6'b110_000;
        if (tick) state_d = haz_req ? HAZ : L3;
      end
      L3: begin
        lamps = 6'b111_000;
        if (tick) state_d = haz_req ? HAZ : IDLE;
      end
      R1: begin
        lamps = 6'b000_100;
        if (tick) state_d = haz_req ? HAZ : R2;
      end
      R2: begin
        lamps = 6'b000_110;
        if (tick) state_d = haz_req ? HAZ : R3;
      end
      R3: begin
        lamps = 6'b000_111;
        if (tick) state_d = haz_req ? HAZ : IDLE;
      end
`ifdef TAIL_LIGHT_HAZARD_EN
      HAZ: begin
        lamps = 6'b111_111;
        if (tick) state_d = IDLE;
      end
`endif
      default: begin
        lamps = 6'b000_000;
        if (tick) state_d = IDLE;
      end
    endcase
  end

  assign {la, lb, lc, ra, rb, rc} = lamps;

endmodule
